// File: rtl/ff_override_arb.sv
// rtl/ff_override_arb.sv - two-requester round-robin override of a live data register
module ff_override_arb #(
  parameter int W  = 8,
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [W-1:0]  d,
  input  logic [1:0]    req,
  input  logic [W-1:0]  val0,
  input  logic [W-1:0]  val1,
  input  logic [CW-1:0] len0,
  input  logic [CW-1:0] len1,
  output logic [1:0]    gnt,
  output logic [W-1:0]  q,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {IDLE, HOLD, RELEASE} state_t;

  state_t        state, state_nxt;
  logic [W-1:0]  q_reg;
  logic [W-1:0]  ov_val;
  logic [CW-1:0] cnt;
  logic          ptr;
  logic          gsel;
  logic          winner;

  // ptr holds the last-served requester; on contention the other one wins
  assign winner = (req == 2'b11) ? ~ptr : ~req[0];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req != 2'b00) state_nxt = HOLD;
      HOLD:    if (!req[gsel] || cnt == '0) state_nxt = RELEASE;
      RELEASE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_reg  <= '0;
      ov_val <= '0;
      cnt    <= '0;
      ptr    <= 1'b1;
      gsel   <= 1'b0;
    end else begin
      q_reg <= d;
      if (state == IDLE && req != 2'b00) begin
        ov_val <= winner ? val1 : val0;
        cnt    <= winner ? len1 : len0;
        ptr    <= winner;
        gsel   <= winner;
      end else if (state == HOLD && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  always_comb begin
    gnt  = 2'b00;
    q    = q_reg;
    busy = 1'b0;
    done = 1'b0;
    case (state)
      HOLD: begin
        gnt  = gsel ? 2'b10 : 2'b01;
        q    = ov_val;
        busy = 1'b1;
      end
      RELEASE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ff_override_arb.sv
// tb/tb_ff_override_arb.sv - randomized and directed checks of ff_override_arb against a cycle model
module tb_ff_override_arb;
  localparam int W  = 8;
  localparam int CW = 4;
  localparam int P_IDLE = 0, P_HOLD = 1, P_REL = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  d, val0, val1;
  logic [1:0]    req;
  logic [CW-1:0] len0, len1;
  logic [1:0]    gnt;
  logic [W-1:0]  q;
  logic          busy, done;

  int n_checks = 0;
  int n_fail   = 0;

  // model: phase, who holds, cycles of hold remaining, latched value, last served
  int            m_phase;
  int            m_left;
  logic          m_who, m_last;
  logic [W-1:0]  m_ov, m_qreg;
  logic [W-1:0]  exp_q;
  logic [1:0]    exp_gnt;
  logic          exp_busy, exp_done;

  ff_override_arb #(.W(W), .CW(CW)) dut (
    .clk(clk), .rst(rst), .d(d), .req(req), .val0(val0), .val1(val1),
    .len0(len0), .len1(len1), .gnt(gnt), .q(q), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic string show();
    return $sformatf("got q=%h gnt=%b busy=%b done=%b, expected q=%h gnt=%b busy=%b done=%b",
                     q, gnt, busy, done, exp_q, exp_gnt, exp_busy, exp_done);
  endfunction

  task automatic cycle();
    logic w;
    @(posedge clk);
    if (rst) begin
      m_phase = P_IDLE; m_left = 0; m_who = 1'b0; m_last = 1'b1; m_ov = '0; m_qreg = '0;
    end else begin
      case (m_phase)
        P_IDLE: if (req != 2'b00) begin
          w = (req == 2'b11) ? ~m_last : ~req[0];
          m_who = w; m_last = w;
          m_left = (w ? int'(len1) : int'(len0)) + 1;
          m_ov = w ? val1 : val0;
          m_phase = P_HOLD;
        end
        P_HOLD: begin
          m_left = m_left - 1;
          if (!req[m_who] || m_left == 0) m_phase = P_REL;
        end
        default: m_phase = P_IDLE;
      endcase
      m_qreg = d;
    end
    #1;
    exp_gnt  = (m_phase == P_HOLD) ? (m_who ? 2'b10 : 2'b01) : 2'b00;
    exp_q    = (m_phase == P_HOLD) ? m_ov : m_qreg;
    exp_busy = (m_phase != P_IDLE);
    exp_done = (m_phase == P_REL);
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 2'b11; d = 8'h77; val0 = 8'h12; val1 = 8'h34; len0 = 4'd1; len1 = 4'd1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      if ({q, gnt, busy, done} !== {W'(0), 2'b00, 1'b0, 1'b0}) begin
        n_fail++; $display("FAIL reset_outputs: %s", show());
      end
      n_checks++;
    end
    rst = 1'b0; req = 2'b00;
    cycle();
    if ({q, gnt, busy, done} !== {exp_q, exp_gnt, exp_busy, exp_done} || q !== 8'h77) begin
      n_fail++; $display("FAIL reset_release: %s", show());
    end
    n_checks++;
  endtask

  task automatic test_basic_hold();
    int hold_n = 0, done_n = 0;
    logic [W-1:0] rel_q = '0;
    d = 8'h11; val0 = 8'hA5; len0 = 4'd2; req = 2'b01;
    for (int i = 0; i < 6; i++) begin
      cycle();
      if ({q, gnt, busy, done} !== {exp_q, exp_gnt, exp_busy, exp_done}) begin
        n_fail++; $display("FAIL basic_model cyc%0d: %s", i, show());
      end
      n_checks++;
      if (gnt == 2'b01 && q == 8'hA5) hold_n++;
      if (done) begin done_n++; rel_q = q; req = 2'b00; end
    end
    if (hold_n != 3 || done_n != 1 || rel_q !== 8'h11) begin
      n_fail++; $display("FAIL basic_counts: hold=%0d done=%0d relq=%h, expected 3 1 11", hold_n, done_n, rel_q);
    end
    n_checks++;
  endtask

  task automatic test_round_robin();
    logic [1:0] gseq[$];
    int gcyc[$];
    logic [1:0] prev = 2'b00;
    logic [1:0] exp_rr [4];
    exp_rr = '{2'b01, 2'b10, 2'b01, 2'b10};
    rst = 1'b1; req = 2'b11; len0 = 4'd0; len1 = 4'd0;
    cycle();
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      cycle();
      if ({q, gnt, busy, done} !== {exp_q, exp_gnt, exp_busy, exp_done}) begin
        n_fail++; $display("FAIL rr_model cyc%0d: %s", i, show());
      end
      n_checks++;
      if (gnt != 2'b00 && prev == 2'b00) begin gseq.push_back(gnt); gcyc.push_back(i); end
      prev = gnt;
    end
    if (gseq.size() < 4) begin
      n_fail++; $display("FAIL rr_count: got %0d grants, expected at least 4", gseq.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (gseq[k] !== exp_rr[k]) begin
          n_fail++; $display("FAIL rr_order%0d: got %b expected %b", k, gseq[k], exp_rr[k]);
        end
        n_checks++;
        if (k > 0 && gcyc[k] - gcyc[k-1] != 3) begin
          n_fail++; $display("FAIL rr_gap%0d: got %0d expected 3", k, gcyc[k] - gcyc[k-1]);
        end
      end
    end
    n_checks++;
    req = 2'b00;
    for (int i = 0; i < 3; i++) cycle();
  endtask

  task automatic test_live_tracking();
    logic [W-1:0] d_edge;
    req = 2'b10; val1 = 8'hFF; len1 = 4'd3; d = 8'h40;
    for (int i = 0; i < 8; i++) begin
      d_edge = d;
      cycle();
      if ({q, gnt, busy, done} !== {exp_q, exp_gnt, exp_busy, exp_done}) begin
        n_fail++; $display("FAIL live_model cyc%0d: %s", i, show());
      end
      n_checks++;
      if (gnt == 2'b10 && q !== 8'hFF) begin
        n_fail++; $display("FAIL live_hold cyc%0d: got q=%h expected ff", i, q);
      end
      if (done) begin
        if (q !== d_edge) begin
          n_fail++; $display("FAIL live_release: got q=%h expected %h", q, d_edge);
        end
        n_checks++;
        req = 2'b00;
      end
      d = d + 8'd1;
    end
  endtask

  task automatic test_abort();
    int done_n = 0;
    req = 2'b01; len0 = 4'd15; val0 = 8'h3C;
    cycle(); cycle();
    req = 2'b00;
    cycle();
    if (done !== 1'b1 || gnt !== 2'b00 || q !== d) begin
      n_fail++; $display("FAIL abort_release: %s", show());
    end
    n_checks++;
    done_n = 1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      if ({q, gnt, busy, done} !== {exp_q, exp_gnt, exp_busy, exp_done}) begin
        n_fail++; $display("FAIL abort_model cyc%0d: %s", i, show());
      end
      n_checks++;
      if (done) done_n++;
    end
    if (done_n != 1) begin
      n_fail++; $display("FAIL abort_done_count: got %0d expected 1", done_n);
    end
    n_checks++;
  endtask

  task automatic test_reset_mid_hold();
    req = 2'b01; len0 = 4'd5; val0 = 8'hC3; d = 8'h9E;
    cycle(); cycle();
    rst = 1'b1;
    cycle();
    if ({q, gnt, busy, done} !== {W'(0), 2'b00, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL midhold_reset: %s", show());
    end
    n_checks++;
    req = 2'b11;
    cycle();
    if (gnt !== 2'b00 || done !== 1'b0) begin
      n_fail++; $display("FAIL midhold_no_grant_in_rst: %s", show());
    end
    n_checks++;
    rst = 1'b0;
    cycle();
    if (gnt !== 2'b01) begin
      n_fail++; $display("FAIL midhold_first_after_rst: got gnt=%b expected 01", gnt);
    end
    n_checks++;
    req = 2'b00;
    for (int i = 0; i < 3; i++) begin
      cycle();
      if ({q, gnt, busy, done} !== {exp_q, exp_gnt, exp_busy, exp_done}) begin
        n_fail++; $display("FAIL midhold_model cyc%0d: %s", i, show());
      end
      n_checks++;
    end
  endtask

  task automatic test_boundary();
    int hold_n = 0;
    req = 2'b10; len1 = 4'd15; val1 = 8'h5A;
    for (int i = 0; i < 20; i++) begin
      d = W'($urandom);
      cycle();
      if ({q, gnt, busy, done} !== {exp_q, exp_gnt, exp_busy, exp_done}) begin
        n_fail++; $display("FAIL bound_model cyc%0d: %s", i, show());
      end
      n_checks++;
      if ((gnt & (gnt - 2'b01)) != 2'b00 || (done && gnt != 2'b00)) begin
        n_fail++; $display("FAIL bound_onehot cyc%0d: got gnt=%b done=%b", i, gnt, done);
      end
      if (gnt == 2'b10) hold_n++;
      if (done) req = 2'b00;
    end
    if (hold_n != 16) begin
      n_fail++; $display("FAIL bound_hold_len: got %0d expected 16", hold_n);
    end
    n_checks++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 7) == 0) req = 2'($urandom);
      d = W'($urandom); val0 = W'($urandom); val1 = W'($urandom);
      len0 = CW'($urandom_range(0, 3)); len1 = CW'($urandom);
      cycle();
      if ({q, gnt, busy, done} !== {exp_q, exp_gnt, exp_busy, exp_done}) begin
        n_fail++; $display("FAIL random_model cyc%0d: %s", i, show());
      end
      n_checks++;
      if ((gnt & (gnt - 2'b01)) != 2'b00 || (done && gnt != 2'b00)) begin
        n_fail++; $display("FAIL random_onehot cyc%0d: got gnt=%b done=%b", i, gnt, done);
      end
      n_checks++;
    end
  endtask

  initial begin
    m_phase = P_IDLE; m_left = 0; m_who = 1'b0; m_last = 1'b1; m_ov = '0; m_qreg = '0;
    test_reset();
    test_basic_hold();
    test_round_robin();
    test_live_tracking();
    test_abort();
    test_reset_mid_hold();
    test_boundary();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
